// File: rtl/pengo_input_ctrl.sv
// Player input conditioning for the Pengo core.
// Decodes hps_io keyboard events and merges them with the joysticks.
// Applies the Vert/Horz direction remap.
// Turns start presses into timed coin pulses.
// Drives the active-low in0/in1 buses of pacman_machine.
module pengo_input_ctrl #(
    parameter int COIN_PULSE   = 24,
    parameter int COIN_HOLDOFF = 48
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic [7:0]  in0_reg,
    output logic [7:0]  in1_reg,
    output logic        coin_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } coin_state_t;

    localparam logic [15:0] PULSE_LOAD = 16'(COIN_PULSE - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(COIN_HOLDOFF - 1);

    // Keyboard event decode
    logic       toggle_prev;
    logic       key_event;
    logic       pressed;
    logic       ext;
    logic [8:0] code;

    // Latched key state
    logic key_up, key_down, key_left, key_right, key_fire, key_s1, key_s2;

    // Merged and remapped controls
    logic up, down, left, right, fire, s1, s2;

    // Coin sequencer
    coin_state_t state, state_next;
    logic [15:0] count, count_next;
    logic        pending, pending_next;
    logic        start_prev;
    logic        trig;
    logic        coin;

    // Joystick bits above start2 are not used by this machine.
    logic unused_joy;
    assign unused_joy = ^joy[15:7];

    assign key_event = ps2_key[64] ^ toggle_prev;
    assign pressed   = (ps2_key[15:8] != 8'hF0);
    assign ext       = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    // Any junk in the upper bytes makes the event unrecognisable.
    assign code      = (|ps2_key[63:24]) ? 9'h000 : {ext, ps2_key[7:0]};

    // Track the event toggle and update key latches on each new event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_prev <= 1'b0;
            key_up      <= 1'b0;
            key_down    <= 1'b0;
            key_left    <= 1'b0;
            key_right   <= 1'b0;
            key_fire    <= 1'b0;
            key_s1      <= 1'b0;
            key_s2      <= 1'b0;
        end else begin
            toggle_prev <= ps2_key[64];
            if (key_event) begin
                // Arrow keys match with or without the E0 prefix.
                if (code[7:0] == 8'h75 && code != 9'h000) key_up    <= pressed;
                if (code[7:0] == 8'h72)                   key_down  <= pressed;
                if (code[7:0] == 8'h6B)                   key_left  <= pressed;
                if (code[7:0] == 8'h74)                   key_right <= pressed;
                if (code == 9'h029 || code == 9'h014)     key_fire  <= pressed;
                if (code == 9'h005)                       key_s1    <= pressed;
                if (code == 9'h006)                       key_s2    <= pressed;
            end
        end
    end

    // Merge keyboard with joystick and rotate directions for Horz orientation.
    always_comb begin
        up    = key_up    | joy[3];
        down  = key_down  | joy[2];
        left  = key_left  | joy[1];
        right = key_right | joy[0];
        if (rotate) begin
            up    = key_left  | joy[1];
            down  = key_right | joy[0];
            left  = key_down  | joy[2];
            right = key_up    | joy[3];
        end
        fire = key_fire | joy[4];
        s1   = key_s1   | joy[5];
        s2   = key_s2   | joy[6];
    end

    assign trig = (s1 | s2) & ~start_prev;
    assign coin = (state == PULSE);

    // Coin sequencer registers and start edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= 16'd0;
            pending    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            pending    <= pending_next;
            start_prev <= s1 | s2;
        end
    end

    // Coin sequencer next-state: pulse, holdoff gap, one queued request.
    always_comb begin
        state_next   = state;
        count_next   = count;
        pending_next = pending;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_next = PULSE;
                    count_next = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (trig) pending_next = 1'b1;
                if (ce) begin
                    if (count == 16'd0) begin
                        state_next = HOLD;
                        count_next = HOLD_LOAD;
                    end else begin
                        count_next = count - 16'd1;
                    end
                end
            end
            HOLD: begin
                if (trig) pending_next = 1'b1;
                if (ce) begin
                    if (count == 16'd0) begin
                        if (pending) begin
                            state_next   = PULSE;
                            count_next   = PULSE_LOAD;
                            pending_next = trig;
                        end else if (trig) begin
                            // A press landing on the exit goes straight to a pulse.
                            state_next   = PULSE;
                            count_next   = PULSE_LOAD;
                            pending_next = 1'b0;
                        end else begin
                            state_next   = IDLE;
                            pending_next = 1'b0;
                        end
                    end else begin
                        count_next = count - 16'd1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                count_next   = 16'd0;
                pending_next = 1'b0;
            end
        endcase
    end

    // Registered active-low outputs toward pacman_machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in0_reg   <= 8'hFF;
            in1_reg   <= 8'hFF;
            coin_busy <= 1'b0;
        end else begin
            in0_reg   <= ~{fire, 2'b00, coin, right, left, down, up};
            in1_reg   <= ~{1'b0, s2, s1, 5'b00000};
            coin_busy <= (state != IDLE);
        end
    end

endmodule
